// File: rtl/prototype_glue.sv
// 68000 prototype board glue: clock/POR, address decode, bus termination, I/O registers, VGA sync.
// Optional SPI master is built when GLUE_SPI_EN is defined.
module prototype_glue #(
    parameter int unsigned POR_CYCLES = 2048,
    parameter int unsigned H_TOTAL    = 800,
    parameter int unsigned V_TOTAL    = 525
) (
    input  logic        sysclk,
    input  logic        sysrst_n,
    input  logic        cclk,
    input  logic [23:0] logaddr,
    output logic [19:12] physaddr,
    output logic        re_n,
    output logic        we_n,
    output logic [2:0]  ipl_n,
    output logic        berr_n,
    output logic        dtack_n,
    input  logic        w_n,
    input  logic        lds_n,
    input  logic        uds_n,
    input  logic        as_n,
    output logic        cpuclk,
    inout  wire  [15:0] d,
    output logic        hsync,
    output logic        vsync,
    output logic        br_n,
    input  logic        bg_n,
    output logic        csram1_n,
    output logic        csram2_n,
    output logic        csrom_n,
    output logic        avec_n,
    output logic        cpurst_n,
    output logic        halt_n,
    input  logic [2:0]  fc,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_ss,
    output logic        spi_sck,
    output logic        spi_channel,
    output logic        avr_tx,
    input  logic        avr_rx,
    input  logic        avr_rx_busy
);
    localparam int unsigned PW = $clog2(POR_CYCLES + 1);
    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    logic [PW-1:0] por_cnt;
    logic          por_done;
    logic          active, iack, in_lo, in_ram2, in_rom, in_io;
    logic          sel_rom_ovl, sel_ram1, sel_ram2, sel_rom, io_ok, bad, ack_dec;
    logic          cs_rom, cs_ram1, cs_ram2, mem_cs;
    logic          dtack_q, berr_q, avec_q;
    logic          overlay, io_wr;
    logic [11:0]   colour;
    logic [15:0]   io_off, rd_data, spi_data_rd;
    logic          spi_busy_rd, spi_ss_q, spi_ch_q;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          visible;
    logic          unused_ok;

    assign por_done = (por_cnt == PW'(POR_CYCLES));
    assign cpurst_n = por_done;
    assign halt_n   = por_done;
    assign ipl_n    = 3'b111;
    assign br_n     = 1'b1;
    assign avr_tx   = 1'b1;

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            por_cnt <= '0;
            cpuclk  <= 1'b0;
        end else begin
            cpuclk <= ~cpuclk;
            if (!por_done)
                por_cnt <= por_cnt + PW'(1);
        end
    end

    // Overlay maps ROM over the low megabyte for reads only; writes there still reach RAM1.
    always_comb begin
        active      = !as_n && por_done;
        iack        = (fc == 3'b111);
        in_lo       = (logaddr[23:20] == 4'h0);
        in_ram2     = (logaddr[23:20] == 4'h1);
        in_rom      = (logaddr[23:19] == 5'b11110);
        in_io       = (logaddr[23:16] == 8'hFF);
        sel_rom_ovl = !iack && in_lo && overlay && w_n;
        sel_ram1    = !iack && in_lo && !sel_rom_ovl;
        sel_ram2    = !iack && in_ram2;
        sel_rom     = !iack && in_rom;
        io_ok       = !iack && in_io && fc[2];
        bad         = !iack && !(in_lo || in_ram2 || in_rom || io_ok);
        ack_dec     = sel_ram1 || sel_ram2 || sel_rom || sel_rom_ovl || io_ok;
        cs_rom      = active && (sel_rom_ovl || (sel_rom && w_n));
        cs_ram1     = active && sel_ram1;
        cs_ram2     = active && sel_ram2;
        mem_cs      = cs_rom || cs_ram1 || cs_ram2;
    end

    assign csrom_n  = !cs_rom;
    assign csram1_n = !cs_ram1;
    assign csram2_n = !cs_ram2;
    assign physaddr = mem_cs ? logaddr[19:12] : '0;
    assign re_n     = !(mem_cs && w_n);
    assign we_n     = !(active && !w_n && (!uds_n || !lds_n) && (sel_ram1 || sel_ram2));
    assign dtack_n  = !dtack_q;
    assign berr_n   = !berr_q;
    assign avec_n   = !avec_q;

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            dtack_q <= 1'b0;
            berr_q  <= 1'b0;
            avec_q  <= 1'b0;
        end else begin
            dtack_q <= active && ack_dec;
            berr_q  <= active && bad;
            avec_q  <= active && iack;
        end
    end

    // Register writes land once, on the edge that first asserts dtack.
    assign io_off = logaddr[15:0];
    assign io_wr  = active && io_ok && !w_n && !dtack_q && (!uds_n || !lds_n);

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            overlay <= 1'b1;
            colour  <= '0;
        end else if (io_wr) begin
            if (io_off == 16'h0000 && !d[0])
                overlay <= 1'b0;
            if (io_off == 16'h0008)
                colour <= d[11:0];
        end
    end

    always_comb begin
        rd_data = '0;
        case (io_off)
            16'h0000: rd_data = {15'd0, overlay};
            16'h0002: rd_data = spi_data_rd;
            16'h0004: rd_data = {spi_busy_rd, 13'd0, spi_ch_q, spi_ss_q};
            16'h0006: rd_data = {14'd0, avr_rx_busy, avr_rx};
            16'h0008: rd_data = {4'd0, colour};
            default:  rd_data = '0;
        endcase
    end

    assign d = (active && io_ok && w_n) ? rd_data : 'z;

`ifdef GLUE_SPI_EN
    logic       spi_busy;
    logic [4:0] spi_cnt;
    logic [7:0] spi_tx, spi_rx;

    // Mode 0 at sysclk/4: sck high in phases 2-3, sample on rising edge, shift after falling.
    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            spi_busy <= 1'b0;
            spi_cnt  <= '0;
            spi_tx   <= '0;
            spi_rx   <= '0;
            spi_ss_q <= 1'b1;
            spi_ch_q <= 1'b0;
        end else begin
            if (io_wr && io_off == 16'h0004)
                {spi_ch_q, spi_ss_q} <= d[1:0];
            if (spi_busy) begin
                spi_cnt <= spi_cnt + 5'd1;
                if (spi_cnt[1:0] == 2'd1)
                    spi_rx <= {spi_rx[6:0], spi_miso};
                if (spi_cnt[1:0] == 2'd3)
                    spi_tx <= {spi_tx[6:0], 1'b0};
                if (spi_cnt == 5'd31)
                    spi_busy <= 1'b0;
            end else if (io_wr && io_off == 16'h0002) begin
                spi_busy <= 1'b1;
                spi_cnt  <= '0;
                spi_tx   <= d[7:0];
            end
        end
    end

    assign spi_sck     = spi_busy && spi_cnt[1];
    assign spi_mosi    = spi_busy && spi_tx[7];
    assign spi_data_rd = {8'd0, spi_rx};
    assign spi_busy_rd = spi_busy;
`else
    assign spi_sck     = 1'b0;
    assign spi_mosi    = 1'b0;
    assign spi_ss_q    = 1'b1;
    assign spi_ch_q    = 1'b0;
    assign spi_data_rd = '0;
    assign spi_busy_rd = 1'b0;
`endif
    assign spi_ss      = spi_ss_q;
    assign spi_channel = spi_ch_q;

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    assign hsync   = !(h_cnt >= HW'(656) && h_cnt <= HW'(751));
    assign vsync   = !(v_cnt >= VW'(490) && v_cnt <= VW'(491));
    assign visible = (h_cnt < HW'(640)) && (v_cnt < VW'(480));
    assign red     = visible ? colour[11:8] : '0;
    assign green   = visible ? colour[7:4]  : '0;
    assign blue    = visible ? colour[3:0]  : '0;

    assign unused_ok = ^{cclk, bg_n, spi_miso, d[15:12]};

endmodule

// File: tb/tb_prototype_glue.sv
// Directed self-checking bench for prototype_glue (default build, SPI master disabled).
module tb_prototype_glue;
    logic        sysclk = 1'b0, sysrst_n = 1'b0, cclk = 1'b0;
    logic [23:0] logaddr = '0;
    logic        w_n = 1'b1, lds_n = 1'b1, uds_n = 1'b1, as_n = 1'b1, bg_n = 1'b1;
    logic [2:0]  fc = 3'b110;
    logic        spi_miso = 1'b0, avr_rx = 1'b0, avr_rx_busy = 1'b0;
    logic [19:12] physaddr;
    logic        re_n, we_n, berr_n, dtack_n, cpuclk, hsync, vsync, br_n;
    logic        csram1_n, csram2_n, csrom_n, avec_n, cpurst_n, halt_n;
    logic [2:0]  ipl_n;
    logic [3:0]  red, green, blue;
    logic        spi_mosi, spi_ss, spi_sck, spi_channel, avr_tx;
    wire  [15:0] d;
    logic [15:0] d_drv = '0;
    logic        d_oe = 1'b0;
    int          checks = 0, errors = 0;
    int unsigned cyc = 0;
    logic        prev_clk;

    assign d = d_oe ? d_drv : 'z;

    prototype_glue #(.POR_CYCLES(2048), .H_TOTAL(800), .V_TOTAL(525)) dut (
        .sysclk(sysclk), .sysrst_n(sysrst_n), .cclk(cclk), .logaddr(logaddr),
        .physaddr(physaddr), .re_n(re_n), .we_n(we_n), .ipl_n(ipl_n),
        .berr_n(berr_n), .dtack_n(dtack_n), .w_n(w_n), .lds_n(lds_n),
        .uds_n(uds_n), .as_n(as_n), .cpuclk(cpuclk), .d(d), .hsync(hsync),
        .vsync(vsync), .br_n(br_n), .bg_n(bg_n), .csram1_n(csram1_n),
        .csram2_n(csram2_n), .csrom_n(csrom_n), .avec_n(avec_n),
        .cpurst_n(cpurst_n), .halt_n(halt_n), .fc(fc), .red(red),
        .green(green), .blue(blue), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_ss(spi_ss), .spi_sck(spi_sck), .spi_channel(spi_channel),
        .avr_tx(avr_tx), .avr_rx(avr_rx), .avr_rx_busy(avr_rx_busy)
    );

    always #5 sysclk = ~sysclk;

    // Edges since reset release; the video counters start from zero on the first one.
    always @(posedge sysclk) if (sysrst_n) cyc <= cyc + 1;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cs(input string tag, input logic r1, input logic r2, input logic rom);
        chk1({tag, "_csram1"}, csram1_n, r1);
        chk1({tag, "_csram2"}, csram2_n, r2);
        chk1({tag, "_csrom"}, csrom_n, rom);
    endtask

    task automatic start(input logic [23:0] a, input logic [2:0] f, input logic wn,
                         input logic [15:0] wd);
        @(negedge sysclk);
        logaddr = a; fc = f; w_n = wn; uds_n = 1'b0; lds_n = 1'b0;
        d_drv = wd; d_oe = !wn; as_n = 1'b0;
        #1;
    endtask

    task automatic edge1;
        @(posedge sysclk); #1;
    endtask

    task automatic stop;
        @(negedge sysclk);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; d_oe = 1'b0; w_n = 1'b1;
        @(posedge sysclk); #1;
    endtask

    initial begin
        #2;
        chk1("rst_cpuclk", cpuclk, 1'b0);
        chk1("rst_cpurst", cpurst_n, 1'b0);
        chk1("rst_halt", halt_n, 1'b0);
        chk_cs("rst", 1'b1, 1'b1, 1'b1);
        chk1("rst_dtack", dtack_n, 1'b1);
        chk1("rst_berr", berr_n, 1'b1);
        chk1("rst_avec", avec_n, 1'b1);
        chk1("rst_re", re_n, 1'b1);
        chk1("rst_we", we_n, 1'b1);
        chk1("rst_hsync", hsync, 1'b1);
        chk1("rst_vsync", vsync, 1'b1);
        chkv("rst_rgb", {4'h0, red, green, blue}, 16'h0000);
        chkv("tieoffs", {10'h0, ipl_n, br_n, avr_tx, spi_ss}, 16'h003F);
        chkv("spi_off", {13'h0, spi_mosi, spi_sck, spi_channel}, 16'h0000);

        #20;
        @(negedge sysclk) sysrst_n = 1'b1;
        repeat (2047) @(posedge sysclk);
        #1;
        chk1("por_2047_cpurst", cpurst_n, 1'b0);
        chk1("por_2047_halt", halt_n, 1'b0);
        prev_clk = cpuclk;
        edge1();
        chk1("por_2048_cpurst", cpurst_n, 1'b1);
        chk1("por_2048_halt", halt_n, 1'b1);
        chk1("cpuclk_toggle", cpuclk, ~prev_clk);

        // Overlay reads from the low megabyte go to ROM.
        start(24'h000000, 3'b110, 1'b1, 16'h0);
        chk_cs("ovl0", 1'b1, 1'b1, 1'b0);
        chkv("ovl0_phys", {8'h0, physaddr}, 16'h0000);
        chk1("ovl0_re", re_n, 1'b0);
        chk1("ovl0_dtack_pre", dtack_n, 1'b1);
        edge1();
        chk1("ovl0_dtack", dtack_n, 1'b0);
        stop();
        chk1("ovl0_dtack_rel", dtack_n, 1'b1);

        start(24'h000004, 3'b110, 1'b1, 16'h0);
        chk_cs("ovl4", 1'b1, 1'b1, 1'b0);
        chkv("ovl4_phys", {8'h0, physaddr}, 16'h0000);
        edge1();
        chk1("ovl4_dtack", dtack_n, 1'b0);
        stop();

        start(24'hFF0000, 3'b110, 1'b1, 16'h0);
        chkv("ctrl_rd1", d, 16'h0001);
        chk_cs("ctrl_rd1", 1'b1, 1'b1, 1'b1);
        edge1();
        chk1("ctrl_rd1_dtack", dtack_n, 1'b0);
        stop();

        start(24'hFF0000, 3'b101, 1'b0, 16'h0000);
        chk1("ctrl_wr_we", we_n, 1'b1);
        edge1();
        chk1("ctrl_wr_dtack", dtack_n, 1'b0);
        stop();

        start(24'hFF0000, 3'b110, 1'b1, 16'h0);
        chkv("ctrl_rd0", d, 16'h0000);
        stop();

        start(24'h000000, 3'b101, 1'b0, 16'h1234);
        chk_cs("ram1_wr", 1'b0, 1'b1, 1'b1);
        chk1("ram1_wr_we", we_n, 1'b0);
        chk1("ram1_wr_re", re_n, 1'b1);
        edge1();
        chk1("ram1_wr_dtack", dtack_n, 1'b0);
        stop();

        start(24'h0AB002, 3'b110, 1'b1, 16'h0);
        chk_cs("ram1_rd", 1'b0, 1'b1, 1'b1);
        chkv("ram1_rd_phys", {8'h0, physaddr}, 16'h00AB);
        chk1("ram1_rd_re", re_n, 1'b0);
        stop();

        start(24'h1FF000, 3'b010, 1'b1, 16'h0);
        chk_cs("ram2_rd", 1'b1, 1'b0, 1'b1);
        chkv("ram2_rd_phys", {8'h0, physaddr}, 16'h00FF);
        edge1();
        chk1("ram2_rd_dtack", dtack_n, 1'b0);
        stop();

        start(24'hF7F000, 3'b110, 1'b1, 16'h0);
        chk_cs("rom_rd", 1'b1, 1'b1, 1'b0);
        chkv("rom_rd_phys", {8'h0, physaddr}, 16'h007F);
        stop();

        start(24'hF00000, 3'b101, 1'b0, 16'hAAAA);
        chk_cs("rom_wr", 1'b1, 1'b1, 1'b1);
        chk1("rom_wr_we", we_n, 1'b1);
        edge1();
        chk1("rom_wr_dtack", dtack_n, 1'b0);
        chk1("rom_wr_berr", berr_n, 1'b1);
        stop();

        start(24'h800000, 3'b110, 1'b1, 16'h0);
        chk_cs("unmapped", 1'b1, 1'b1, 1'b1);
        chk1("unmapped_re", re_n, 1'b1);
        chkv("unmapped_phys", {8'h0, physaddr}, 16'h0000);
        edge1();
        chk1("unmapped_berr", berr_n, 1'b0);
        chk1("unmapped_dtack", dtack_n, 1'b1);
        stop();
        chk1("unmapped_berr_rel", berr_n, 1'b1);

        start(24'hFF0000, 3'b001, 1'b1, 16'h0);
        edge1();
        chk1("user_io_berr", berr_n, 1'b0);
        chk1("user_io_dtack", dtack_n, 1'b1);
        stop();

        start(24'hFFFFFE, 3'b111, 1'b1, 16'h0);
        chk_cs("iack", 1'b1, 1'b1, 1'b1);
        edge1();
        chk1("iack_avec", avec_n, 1'b0);
        chk1("iack_dtack", dtack_n, 1'b1);
        chk1("iack_berr", berr_n, 1'b1);
        stop();
        chk1("iack_avec_rel", avec_n, 1'b1);

        avr_rx = 1'b1; avr_rx_busy = 1'b0;
        start(24'hFF0006, 3'b110, 1'b1, 16'h0);
        chkv("avr_stat", d, 16'h0001);
        stop();
        avr_rx = 1'b0; avr_rx_busy = 1'b1;
        start(24'hFF0006, 3'b110, 1'b1, 16'h0);
        chkv("avr_stat2", d, 16'h0002);
        stop();

        start(24'hFF0002, 3'b110, 1'b1, 16'h0);
        chkv("spi_data_off", d, 16'h0000);
        stop();
        start(24'hFF0004, 3'b110, 1'b1, 16'h0);
        chkv("spi_ctrl_off", d, 16'h0001);
        stop();
        start(24'hFF000A, 3'b110, 1'b1, 16'h0);
        chkv("io_other", d, 16'h0000);
        edge1();
        chk1("io_other_dtack", dtack_n, 1'b0);
        stop();

        start(24'hFF0008, 3'b100, 1'b0, 16'h0F00);
        edge1();
        stop();
        start(24'hFF0008, 3'b110, 1'b1, 16'h0);
        chkv("colour_rd", d, 16'h0F00);
        stop();

        // One full line plus a bit, covering visible, front porch, sync and back porch.
        for (int i = 0; i < 900; i++) begin
            int unsigned h, v;
            logic        vis;
            edge1();
            h = cyc % 800;
            v = (cyc / 800) % 525;
            vis = (h < 640) && (v < 480);
            chkv("vid_red", {12'h0, red}, vis ? 16'h000F : 16'h0000);
            chkv("vid_gb", {8'h0, green, blue}, 16'h0000);
            chk1("vid_hsync", hsync, !(h >= 656 && h <= 751));
            chk1("vid_vsync", vsync, !(v >= 490 && v <= 491));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
